// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - two-requester arbiter and scan pacer for a quad 7-segment display
// Requester B (alert) pre-empts A for a fixed number of scan ticks, optionally blinking, then A's latest value returns.
module display_scheduler #(
    parameter int SCAN_DIV    = 27000,
    parameter int HOLD_TICKS  = 2000,
    parameter int BLINK_TICKS = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [15:0] a_number,
    input  logic        a_colon,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [15:0] b_number,
    input  logic        b_colon,
    output logic [15:0] number,
    output logic        colonEnable,
    output logic        scan_tick,
    output logic        owner,
    output logic        blank
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'((BLINK_TICKS > 0) ? BLINK_TICKS - 1 : 0);
    localparam bit            BLINK_ON   = (BLINK_TICKS > 0);

    typedef enum logic {
        SHOW_A = 1'b0,
        SHOW_B = 1'b1
    } state_t;

    state_t          state;
    logic [DW-1:0]   divCnt;
    logic [HW-1:0]   holdCnt;
    logic [BW-1:0]   blinkCnt;
    logic [15:0]     shadowA;
    logic            shadowColon;

    logic aAccept;
    logic bAccept;
    logic tickNow;

    assign aAccept = a_valid & a_ready;
    assign bAccept = b_valid & b_ready;
    // Alert bookkeeping runs on the same edge that raises scan_tick, so blank
    // changes only at digit boundaries.
    assign tickNow = (divCnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SHOW_A;
            divCnt      <= '0;
            holdCnt     <= '0;
            blinkCnt    <= '0;
            shadowA     <= '0;
            shadowColon <= 1'b0;
            number      <= '0;
            colonEnable <= 1'b0;
            scan_tick   <= 1'b0;
            owner       <= 1'b0;
            blank       <= 1'b0;
            a_ready     <= 1'b0;
            b_ready     <= 1'b0;
        end else begin
            a_ready   <= 1'b1;
            b_ready   <= 1'b1;
            scan_tick <= tickNow;
            divCnt    <= tickNow ? '0 : divCnt + 1'b1;

            if (aAccept) begin
                shadowA     <= a_number;
                shadowColon <= a_colon;
            end

            if (bAccept) begin
                // Alert entry or retrigger; A's simultaneous value stays in the shadow.
                state       <= SHOW_B;
                owner       <= 1'b1;
                number      <= b_number;
                colonEnable <= b_colon;
                holdCnt     <= HOLD_LOAD;
                blinkCnt    <= '0;
                blank       <= 1'b0;
            end else begin
                case (state)
                    SHOW_A: begin
                        owner <= 1'b0;
                        blank <= 1'b0;
                        if (aAccept) begin
                            number      <= a_number;
                            colonEnable <= a_colon;
                        end
                    end
                    SHOW_B: begin
                        owner <= 1'b1;
                        if (tickNow) begin
                            if (holdCnt == HOLD_ONE) begin
                                state       <= SHOW_A;
                                owner       <= 1'b0;
                                blank       <= 1'b0;
                                holdCnt     <= '0;
                                blinkCnt    <= '0;
                                number      <= aAccept ? a_number : shadowA;
                                colonEnable <= aAccept ? a_colon  : shadowColon;
                            end else begin
                                holdCnt <= holdCnt - 1'b1;
                                if (BLINK_ON) begin
                                    if (blinkCnt == BLINK_LAST) begin
                                        blinkCnt <= '0;
                                        blank    <= ~blank;
                                    end else begin
                                        blinkCnt <= blinkCnt + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state <= SHOW_A;
                        owner <= 1'b0;
                        blank <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - scoreboard bench for display_scheduler
// A behavioural model predicts outputs per edge; a negedge monitor compares them.
module tb_display_scheduler;

    localparam int SCAN_DIV    = 4;
    localparam int HOLD_TICKS  = 3;
    localparam int BLINK_TICKS = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_colon, b_valid, b_colon;
    logic [15:0] a_number, b_number;
    logic        a_ready, b_ready;
    logic [15:0] number;
    logic        colonEnable, scan_tick, owner, blank;

    display_scheduler #(
        .SCAN_DIV(SCAN_DIV), .HOLD_TICKS(HOLD_TICKS), .BLINK_TICKS(BLINK_TICKS)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_number(a_number), .a_colon(a_colon),
        .b_valid(b_valid), .b_ready(b_ready), .b_number(b_number), .b_colon(b_colon),
        .number(number), .colonEnable(colonEnable), .scan_tick(scan_tick),
        .owner(owner), .blank(blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] num;
        logic        col;
        logic        own;
        logic        blk;
        logic        tck;
        logic        rdy;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   cycle  = 0;

    // Behavioural model: what should be on screen, expressed as counts of events.
    int          mEdges;
    logic [15:0] mAVal, mAlertNum;
    logic        mACol, mAlertCol, mOnB;
    int          mTicksSince;
    bit          mTick;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL cycle %0d %s: got %h expected %h", cycle, name, act, req);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cycle++;
            chk("number",      number,             e.num);
            chk("colonEnable", {15'd0, colonEnable}, {15'd0, e.col});
            chk("owner",       {15'd0, owner},       {15'd0, e.own});
            chk("blank",       {15'd0, blank},       {15'd0, e.blk});
            chk("scan_tick",   {15'd0, scan_tick},   {15'd0, e.tck});
            chk("a_ready",     {15'd0, a_ready},     {15'd0, e.rdy});
            chk("b_ready",     {15'd0, b_ready},     {15'd0, e.rdy});
        end
    end

    task automatic step(input bit r, input bit av, input logic [15:0] an, input bit ac,
                        input bit bv, input logic [15:0] bn, input bit bc);
        exp_t e;
        bit   rdyNow, aAcc, bAcc;
        rst = r; a_valid = av; a_number = an; a_colon = ac;
        b_valid = bv; b_number = bn; b_colon = bc;
        if (r) begin
            mEdges = 0; mAVal = '0; mACol = 0; mOnB = 0;
            mAlertNum = '0; mAlertCol = 0; mTicksSince = 0; mTick = 0;
            e = '{num: 16'h0, col: 1'b0, own: 1'b0, blk: 1'b0, tck: 1'b0, rdy: 1'b0};
        end else begin
            rdyNow = (mEdges >= 1);
            aAcc   = av && rdyNow;
            bAcc   = bv && rdyNow;
            mEdges++;
            mTick  = (mEdges % SCAN_DIV) == 0;
            if (aAcc) begin mAVal = an; mACol = ac; end
            if (bAcc) begin
                mOnB = 1; mAlertNum = bn; mAlertCol = bc; mTicksSince = 0;
            end else if (mOnB && mTick) begin
                mTicksSince++;
                if (mTicksSince == HOLD_TICKS) mOnB = 0;
            end
            e.num = mOnB ? mAlertNum : mAVal;
            e.col = mOnB ? mAlertCol : mACol;
            e.own = mOnB;
            e.blk = mOnB && (BLINK_TICKS > 0) && (((mTicksSince / (BLINK_TICKS > 0 ? BLINK_TICKS : 1)) % 2) == 1);
            e.tck = mTick;
            e.rdy = 1'b1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 0, 16'h0, 0);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 0, 0, 16'h0, 0);
        idle(9);
        step(0, 1, 16'h1234, 1, 0, 16'h0, 0);
        idle(2);
        step(0, 1, 16'h0001, 0, 1, 16'hBEEF, 1);
        idle(14);
        step(0, 0, 16'h0, 0, 1, 16'hCAFE, 0);
        idle(1);
        step(0, 1, 16'h5555, 1, 0, 16'h0, 0);
        idle(1);
        step(0, 1, 16'h6666, 0, 0, 16'h0, 0);
        idle(14);
        // Alert, then retrigger on exactly its second scan_tick edge.
        step(0, 0, 16'h0, 0, 1, 16'hA1E7, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (((mEdges + 1) % SCAN_DIV) == 0) begin
                cnt++;
                if (cnt == 2) begin
                    step(0, 0, 16'h0, 0, 1, 16'hA2E7, 0);
                    break;
                end
            end
            step(0, 0, 16'h0, 0, 0, 16'h0, 0);
        end
        idle(16);
        step(0, 0, 16'h0, 0, 1, 16'hDEAD, 1);
        idle(2);
        step(1, 0, 16'h0, 0, 0, 16'h0, 0);
        idle(2);
        step(0, 1, 16'h7777, 1, 0, 16'h0, 0);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 2) == 0), 16'($urandom), 1'($urandom),
                 ($urandom_range(0, 24) == 0), 16'($urandom), 1'($urandom));
        end
        idle(2);
        @(negedge clk);
        #1;
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
